// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared LC2K word width, loader states and opcode constants.
package lc2k_pkg;
  localparam int WORD_W = 32;
  localparam logic [2:0] OP_HALT = 3'b110;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HALTED, ERROR} state_t;
endpackage

// File: rtl/lc2k_byte_packer.sv
// lc2k_byte_packer: packs big-endian bytes into words, pulsing word_valid the cycle after the 4th byte.
module lc2k_byte_packer
  import lc2k_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              take,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);
  logic [1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= take && cnt == 2'd3;
      if (take) begin
        word <= {word[WORD_W-9:0], data};
        cnt  <= cnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/lc2k_program_loader.sv
// lc2k_program_loader: loads a length-prefixed byte stream into LC2K memory, then runs the CPU until halt.
module lc2k_program_loader
  import lc2k_pkg::*;
#(
  parameter int MEM_DEPTH = 65536,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  input  logic              CONTROL_HALT,
  input  logic              restart,
  output logic              halted,
  output logic              load_error
);
  state_t state, next;
  logic [WORD_W-1:0] word;
  logic word_valid, take, last, bad, clr;
  logic [ADDR_W:0] wcnt, len;
  assign take = byte_valid && byte_ready;
  assign clr = state == HALTED && restart;
  lc2k_byte_packer u_packer (
    .clk(clk),
    .rst(reset),
    .clr(clr),
    .take(take),
    .data(byte_data),
    .word(word),
    .word_valid(word_valid)
  );
  assign bad = word == '0 || word > WORD_W'(MEM_DEPTH);
  assign mem_we = word_valid && state == LOAD;
  assign last = mem_we && wcnt + (ADDR_W+1)'(1) == len;
  assign mem_addr = wcnt[ADDR_W-1:0];
  assign mem_wdata = mem_we ? word : '0;
  // ready drops in the final write cycle so nothing past the program is consumed
  assign byte_ready = state == IDLE || (state == LOAD && !last);
  assign cpu_reset = state != RUN;
  assign halted = state == HALTED;
  assign load_error = state == ERROR;
  always_comb begin
    next = state;
    if (state == IDLE && word_valid) next = bad ? ERROR : LOAD;
    if (state == LOAD && last) next = RUN;
    if (state == RUN && CONTROL_HALT) next = HALTED;
    if (clr) next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
      len   <= '0;
    end else begin
      state <= next;
      wcnt  <= clr ? '0 : wcnt + (ADDR_W+1)'(mem_we);
      len   <= (state == IDLE && word_valid) ? word[ADDR_W:0] : len;
    end
  end
endmodule

// File: tb/tb_lc2k_program_loader.sv
// tb_lc2k_program_loader: random programs checked against an expected write list built from the header and words.
module tb_lc2k_program_loader;
  import lc2k_pkg::*;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 0, reset = 1, byte_valid = 0, restart = 0, ctrl_halt = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, mem_we, cpu_reset, halted, load_error;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  int n_vec = 0, n_err = 0;
  logic [31:0] prog[$];
  logic [AW+31:0] got[$];
  logic prev_we = 0;

  always #5 clk = ~clk;

  lc2k_program_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .CONTROL_HALT(ctrl_halt), .restart(restart),
    .halted(halted), .load_error(load_error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      check("we_single", 32'(prev_we), 0);
      got.push_back({mem_addr, mem_wdata});
    end
    prev_we <= mem_we;
  end

  task automatic check_reset_vals();
    check("rst_ready", 32'(byte_ready), 1);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_cpurst", 32'(cpu_reset), 1);
    check("rst_halted", 32'(halted), 0);
    check("rst_err", 32'(load_error), 0);
  endtask

  task automatic reset_dut();
    reset = 1; byte_valid = 0; restart = 0; ctrl_halt = 0;
    @(negedge clk);
    reset = 0;
    check_reset_vals();
  endtask

  // mode 0: full rate, 1: one idle cycle before every byte, 2: random gaps
  task automatic put_byte(input logic [7:0] b, input int mode);
    int gaps;
    gaps = mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 2));
    repeat (gaps) begin
      byte_valid = 0; byte_data = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1; byte_data = b;
    check("ready", 32'(byte_ready), 1);
    @(negedge clk);
  endtask

  task automatic put_word(input logic [31:0] w, input int mode);
    for (int i = 3; i >= 0; i--) put_byte(w[8*i +: 8], mode);
  endtask

  task automatic load(input int n, input int mode, input bit keep);
    if (!keep) begin
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      prog[n-1] = {7'd0, OP_HALT, 22'd0};
    end
    got.delete();
    put_word(32'(n), mode);
    for (int i = 0; i < n; i++) put_word(prog[i], mode);
    check("last_we", 32'(mem_we), 1);
    check("last_ready", 32'(byte_ready), 0);
    check("last_cpurst", 32'(cpu_reset), 1);
    byte_valid = 1; byte_data = 8'($urandom);
    @(negedge clk);
    check("run_cpurst", 32'(cpu_reset), 0);
    check("run_ready", 32'(byte_ready), 0);
    byte_valid = 0;
    @(negedge clk);
    check("n_writes", 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      check("wr_addr", 32'(got[i][AW+31:32]), 32'(i % DEPTH));
      check("wr_data", got[i][31:0], prog[i]);
    end
  endtask

  task automatic halt_restart();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    ctrl_halt = 1;
    @(negedge clk);
    ctrl_halt = 0;
    check("halt_halted", 32'(halted), 1);
    check("halt_cpurst", 32'(cpu_reset), 1);
    check("halt_ready", 32'(byte_ready), 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    restart = 1;
    @(negedge clk);
    restart = 0;
    check("rs_halted", 32'(halted), 0);
    check("rs_ready", 32'(byte_ready), 1);
    check("rs_cpurst", 32'(cpu_reset), 1);
  endtask

  task automatic bad_header(input logic [31:0] h);
    got.delete();
    put_word(h, 0);
    byte_valid = 0;
    @(negedge clk);
    check("err_flag", 32'(load_error), 1);
    check("err_ready", 32'(byte_ready), 0);
    check("err_cpurst", 32'(cpu_reset), 1);
    byte_valid = 1;
    restart = 1;
    repeat (4) @(negedge clk);
    byte_valid = 0; restart = 0;
    check("err_sticky", 32'(load_error), 1);
    check("err_nowrite", 32'(got.size()), 0);
    reset_dut();
  endtask

  initial begin
    reset_dut();
    prog = '{32'h00810007, 32'h01800000};
    load(2, 0, 1);
    restart = 1;
    @(negedge clk);
    restart = 0;
    check("run_ign_restart", 32'(halted), 0);
    check("run_ign_cpurst", 32'(cpu_reset), 0);
    halt_restart();
    ctrl_halt = 1;
    @(negedge clk);
    ctrl_halt = 0;
    check("idle_ign_halt", 32'(halted), 0);
    load(2, 1, 1);
    ctrl_halt = 1; restart = 1;
    @(negedge clk);
    ctrl_halt = 0; restart = 0;
    check("both_halted", 32'(halted), 1);
    @(negedge clk);
    check("both_stay", 32'(halted), 1);
    restart = 1;
    @(negedge clk);
    restart = 0;
    check("both_restart", 32'(byte_ready), 1);
    load(1, 2, 0);
    reset_dut();
    bad_header(32'h0);
    bad_header(32'(DEPTH + 1));
    bad_header(32'h8000_0000 | $urandom);
    got.delete();
    put_word(32'd3, 0);
    put_byte(8'hAB, 0);
    put_byte(8'hCD, 0);
    reset_dut();
    repeat (2) @(negedge clk);
    check("midrst_nowrite", 32'(got.size()), 0);
    prog = '{32'h00810007};
    load(1, 0, 1);
    reset_dut();
    load(DEPTH, 2, 0);
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) reset_dut();
      else halt_restart();
      load(int'($urandom_range(1, DEPTH)), int'($urandom_range(0, 2)), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
